// File: rtl/transpose_pkg.sv
// Shared types and constants for the transposer initiator controller.
// Element format, engine state encodings and the controller FSM states.
package transpose_pkg;

    localparam int FX_IL = 4;
    localparam int FX_FL = 16;

    typedef logic signed [FX_IL+FX_FL-1:0] fx_t;

    localparam logic [1:0] ENG_IDLE = 2'b00;
    localparam logic [1:0] ENG_BUSY = 2'b01;
    localparam logic [1:0] ENG_DONE = 2'b10;
    localparam logic [1:0] ENG_ERR  = 2'b11;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_DRAIN
    } ctrl_state_t;

endpackage

// File: rtl/tile_row_buffer.sv
// Register array of DEPTH rows x ELEMS elements with a single-row write port,
// a whole-array load port and a full-tile read port; clr zeroes every entry.
module tile_row_buffer #(
    parameter int W     = 20,
    parameter int DEPTH = 16,
    parameter int ELEMS = 256,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic signed [W-1:0] wr_row    [ELEMS],
    input  logic                load_en,
    input  logic signed [W-1:0] load_tile [DEPTH][ELEMS],
    output logic signed [W-1:0] tile      [DEPTH][ELEMS]
);

    // Whole-array load wins over the row port; the two are never used together.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int j = 0; j < ELEMS; j++) begin
                    tile[i][j] <= '0;
                end
            end
        end else if (load_en) begin
            tile <= load_tile;
        end else if (wr_en) begin
            tile[wr_addr] <= wr_row;
        end
    end

endmodule

// File: rtl/transpose_stream_ctrl.sv
// Initiator-side controller for the transposer engine: collects a ROW x COL tile
// row by row, hands it off, captures the COL x ROW result and streams it out.
module transpose_stream_ctrl
    import transpose_pkg::*;
#(
    parameter int IL  = FX_IL,
    parameter int FL  = FX_FL,
    parameter int ROW = 16,
    parameter int COL = 256
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [IL+FL-1:0]   in_row     [COL],
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [IL+FL-1:0]   out_row    [ROW],
    output logic                      out_last,
    output logic                      eng_input_ready,
    input  logic [1:0]                eng_state,
    output logic                      eng_output_taken,
    output logic signed [IL+FL-1:0]   eng_tile   [ROW][COL],
    input  logic signed [IL+FL-1:0]   eng_result [COL][ROW],
    output logic [15:0]               tile_count,
    output logic                      proto_err
);

    localparam int W  = IL + FL;
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int KW = (COL > 1) ? $clog2(COL) : 1;
    localparam logic [RW-1:0] R_LAST = RW'(ROW - 1);
    localparam logic [KW-1:0] K_LAST = KW'(COL - 1);

    ctrl_state_t   state_reg, state_next;
    logic [RW-1:0] r_reg, r_next;
    logic [KW-1:0] k_reg, k_next;
    logic [15:0]   tile_count_reg, tile_count_next;
    logic          proto_err_reg;
    logic          tile_wr;
    logic          result_load;

    logic signed [W-1:0] zero_row  [ROW];
    logic signed [W-1:0] zero_tile [ROW][COL];
    logic signed [W-1:0] result_buf [COL][ROW];

    // Constant ties for the unused port of each buffer instance.
    for (genvar gi = 0; gi < ROW; gi++) begin : g_zero
        assign zero_row[gi] = '0;
        for (genvar gj = 0; gj < COL; gj++) begin : g_zero_col
            assign zero_tile[gi][gj] = '0;
        end
    end

    tile_row_buffer #(
        .W     (W),
        .DEPTH (ROW),
        .ELEMS (COL)
    ) u_tile_buf (
        .clk       (clk),
        .clr       (reset),
        .wr_en     (tile_wr),
        .wr_addr   (r_reg),
        .wr_row    (in_row),
        .load_en   (1'b0),
        .load_tile (zero_tile),
        .tile      (eng_tile)
    );

    // The engine clears its output on the taken edge, so this samples the pre-edge value.
    tile_row_buffer #(
        .W     (W),
        .DEPTH (COL),
        .ELEMS (ROW)
    ) u_result_buf (
        .clk       (clk),
        .clr       (reset),
        .wr_en     (1'b0),
        .wr_addr   ('0),
        .wr_row    (zero_row),
        .load_en   (result_load),
        .load_tile (eng_result),
        .tile      (result_buf)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_LOAD;
            r_reg          <= '0;
            k_reg          <= '0;
            tile_count_reg <= '0;
            proto_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            r_reg          <= r_next;
            k_reg          <= k_next;
            tile_count_reg <= tile_count_next;
            proto_err_reg  <= proto_err_reg | (eng_state == ENG_ERR);
        end
    end

    // Handshake outputs are gated by reset so nothing pulses while the tile is abandoned.
    always_comb begin
        state_next       = state_reg;
        r_next           = r_reg;
        k_next           = k_reg;
        tile_count_next  = tile_count_reg;
        in_ready         = 1'b0;
        out_valid        = 1'b0;
        out_last         = 1'b0;
        eng_input_ready  = 1'b0;
        eng_output_taken = 1'b0;
        tile_wr          = 1'b0;
        result_load      = 1'b0;
        if (!reset) begin
            case (state_reg)
                ST_LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        tile_wr = 1'b1;
                        if (r_reg == R_LAST) begin
                            r_next     = '0;
                            state_next = ST_ISSUE;
                        end else begin
                            r_next = r_reg + RW'(1);
                        end
                    end
                end
                ST_ISSUE: begin
                    eng_input_ready = 1'b1;
                    if (eng_state == ENG_IDLE) begin
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    case (eng_state)
                        ENG_DONE: begin
                            eng_output_taken = 1'b1;
                            result_load      = 1'b1;
                            k_next           = '0;
                            state_next       = ST_DRAIN;
                        end
                        ENG_IDLE, ENG_BUSY, ENG_ERR: begin
                            state_next = ST_WAIT;
                        end
                        default: begin
                            state_next = ST_WAIT;
                        end
                    endcase
                end
                ST_DRAIN: begin
                    out_valid = 1'b1;
                    out_last  = (k_reg == K_LAST);
                    if (out_ready) begin
                        if (k_reg == K_LAST) begin
                            k_next          = '0;
                            tile_count_next = tile_count_reg + 16'd1;
                            state_next      = ST_LOAD;
                        end else begin
                            k_next = k_reg + KW'(1);
                        end
                    end
                end
                default: begin
                    state_next = ST_LOAD;
                end
            endcase
        end
    end

    assign out_row    = result_buf[k_reg];
    assign tile_count = tile_count_reg;
    assign proto_err  = proto_err_reg;

endmodule

// File: tb/tb_transpose_stream_ctrl.sv
// Directed bench for transpose_stream_ctrl at ROW=4, COL=8 with a behavioural
// transposer engine (idle -> busy for one cycle -> done) and an override on state.
module tb_transpose_stream_ctrl;
    import transpose_pkg::*;

    localparam int ROW = 4;
    localparam int COL = 8;
    localparam int W   = 20;

    logic clk = 1'b0;
    logic reset;
    logic in_valid;
    logic in_ready;
    logic signed [W-1:0] in_row     [COL];
    logic out_valid;
    logic out_ready;
    logic signed [W-1:0] out_row    [ROW];
    logic out_last;
    logic eng_input_ready;
    logic [1:0] eng_state;
    logic eng_output_taken;
    logic signed [W-1:0] eng_tile   [ROW][COL];
    logic signed [W-1:0] eng_result [COL][ROW];
    logic [15:0] tile_count;
    logic proto_err;

    logic [1:0] model_state;
    logic       force_en;
    logic [1:0] force_val;
    int         sample_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic rdy;
        logic exp_valid;
        int   exp_k;
        logic exp_last;
    } drain_vec_t;

    drain_vec_t vecs [17];

    always #5 clk = ~clk;

    transpose_stream_ctrl #(
        .IL  (4),
        .FL  (16),
        .ROW (ROW),
        .COL (COL)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_row           (in_row),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_row          (out_row),
        .out_last         (out_last),
        .eng_input_ready  (eng_input_ready),
        .eng_state        (eng_state),
        .eng_output_taken (eng_output_taken),
        .eng_tile         (eng_tile),
        .eng_result       (eng_result),
        .tile_count       (tile_count),
        .proto_err        (proto_err)
    );

    assign eng_state = force_en ? force_val : model_state;

    // Engine: samples in on input_ready while idle, busy one cycle, clears out when taken.
    always @(posedge clk) begin
        if (reset) begin
            model_state  <= ENG_IDLE;
            sample_count <= 0;
            for (int c = 0; c < COL; c++)
                for (int r = 0; r < ROW; r++)
                    eng_result[c][r] <= '0;
        end else begin
            case (model_state)
                ENG_IDLE: if (eng_input_ready && eng_state == ENG_IDLE) begin
                    for (int c = 0; c < COL; c++)
                        for (int r = 0; r < ROW; r++)
                            eng_result[c][r] <= eng_tile[r][c];
                    sample_count <= sample_count + 1;
                    model_state  <= ENG_BUSY;
                end
                ENG_BUSY: model_state <= ENG_DONE;
                ENG_DONE: if (eng_output_taken) begin
                    for (int c = 0; c < COL; c++)
                        for (int r = 0; r < ROW; r++)
                            eng_result[c][r] <= '0;
                    model_state <= ENG_IDLE;
                end
                default: model_state <= ENG_IDLE;
            endcase
        end
    end

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end else begin
            $display("ok   %s: %0d", name, actual);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && eng_input_ready && eng_output_taken) begin
            checks++;
            errors++;
            $display("FAIL handshake_exclusive: input_ready=1 output_taken=1, required not both");
        end
    end

    // Entered just after a negedge; returns at the negedge following the last accept.
    task automatic load_tile(input int base, input int gap);
        for (int r = 0; r < ROW; r++) begin
            int guard = 0;
            for (int c = 0; c < COL; c++) in_row[c] = W'(base + r * COL + c);
            in_valid = 1'b1;
            while (!in_ready && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            if (!in_ready) check("load_timeout", in_ready, 1);
            @(posedge clk);
            @(negedge clk);
            if (gap > 0 && r < ROW - 1) begin
                in_valid = 1'b0;
                repeat (gap - 1) @(negedge clk);
                if (gap > 1) check("in_ready_gap", in_ready, 1);
                @(negedge clk);
            end
        end
        check("in_ready_after_last", in_ready, 0);
        for (int c = 0; c < COL; c++) in_row[c] = W'(12345);
    endtask

    task automatic wait_out_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (in_ready) check("in_ready_blocked", in_ready, 0);
        end
        if (!out_valid) check("out_valid_timeout", out_valid, 1);
    endtask

    task automatic drain_all(input int base);
        int k = 0;
        int guard = 0;
        out_ready = 1'b1;
        while (k < COL && guard < 100) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                for (int j = 0; j < ROW; j++)
                    check($sformatf("out_row_k%0d_j%0d", k, j), out_row[j], base + j * COL + k);
                check($sformatf("out_last_k%0d", k), out_last, (k == COL - 1) ? 1 : 0);
                k++;
            end
        end
        check("drain_beats", k, COL);
        @(negedge clk);
        check("out_valid_after_drain", out_valid, 0);
        check("in_ready_after_drain", in_ready, 1);
    endtask

    initial begin
        int lat;
        int samples0;

        // Stall pattern 1,0,0,1 repeating: expected k advances only after ready beats.
        vecs[0]  = '{1'b1, 1'b1, 0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 1, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 3, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 3, 1'b0};
        vecs[7]  = '{1'b1, 1'b1, 3, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 4, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 5, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 5, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 5, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 6, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 7, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 7, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 7, 1'b1};
        vecs[16] = '{1'b0, 1'b0, 0, 1'b0};

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        force_en  = 1'b0;
        force_val = ENG_IDLE;
        for (int c = 0; c < COL; c++) in_row[c] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_eng_input_ready", eng_input_ready, 0);
        check("rst_eng_output_taken", eng_output_taken, 0);
        check("rst_tile_count", tile_count, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_tile_buf", eng_tile[ROW-1][COL-1], 0);

        // Tile 1: back-to-back rows, idle engine, always-ready sink.
        load_tile(0, 0);
        wait_out_valid(lat);
        in_valid = 1'b0;
        check("latency_tile1", lat, 3);
        drain_all(0);
        check("tile_count_1", tile_count, 1);
        check("samples_tile1", sample_count, 1);

        // Tile 2: sparse input, engine stuck in done at ISSUE, stalled sink.
        force_val = ENG_DONE;
        force_en  = 1'b1;
        load_tile(-100, 2);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                check($sformatf("tile2_r%0d_c%0d", r, c), eng_tile[r][c], -100 + r * COL + c);
        samples0 = sample_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("issue_hold_input_ready", eng_input_ready, 1);
            check("issue_hold_output_taken", eng_output_taken, 0);
            check("issue_hold_out_valid", out_valid, 0);
        end
        check("issue_hold_no_sample", sample_count, samples0);
        force_en = 1'b0;
        wait_out_valid(lat);
        in_valid = 1'b0;
        check("latency_after_release", lat, 3);
        check("issue_one_sample", sample_count, samples0 + 1);
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            out_ready = vecs[i].rdy;
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_out_last", i), out_last, vecs[i].exp_last);
                for (int j = 0; j < ROW; j++)
                    check($sformatf("vec%0d_out_row_j%0d", i, j), out_row[j],
                          -100 + j * COL + vecs[i].exp_k);
            end
        end
        check("tile_count_2", tile_count, 2);

        // Tile 3: one cycle of illegal state 11 while waiting.
        load_tile(-500, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("wait_out_valid0", out_valid, 0);
        check("wait_input_ready0", eng_input_ready, 0);
        check("wait_proto_err0", proto_err, 0);
        force_val = ENG_ERR;
        force_en  = 1'b1;
        @(negedge clk);
        check("err_proto_err", proto_err, 1);
        check("err_hold_out_valid", out_valid, 0);
        check("err_hold_input_ready", eng_input_ready, 0);
        check("err_output_taken", eng_output_taken, 0);
        force_en = 1'b0;
        #1;
        check("err_recover_taken", eng_output_taken, 1);
        wait_out_valid(lat);
        check("err_recover_latency", lat, 1);
        drain_all(-500);
        check("err_proto_sticky", proto_err, 1);
        check("tile_count_3", tile_count, 3);

        // Reset while waiting on a busy engine.
        load_tile(7, 0);
        in_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_eng_state_busy", eng_state, ENG_BUSY);
        reset = 1'b1;
        #1;
        check("rst_wait_output_taken", eng_output_taken, 0);
        check("rst_wait_input_ready", eng_input_ready, 0);
        check("rst_wait_out_valid", out_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_output_taken", eng_output_taken, 0);
        check("post_rst_tile_count", tile_count, 0);
        check("post_rst_proto_err", proto_err, 0);
        check("post_rst_tile_buf", eng_tile[0][1], 0);

        // Reset asserted while ISSUE is driving input_ready.
        load_tile(40, 0);
        in_valid = 1'b0;
        check("issue_input_ready", eng_input_ready, 1);
        reset = 1'b1;
        #1;
        check("rst_issue_input_ready", eng_input_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_issue_in_ready", in_ready, 1);
        check("rst_issue_input_ready_after", eng_input_ready, 0);

        // A normal tile after the aborted ones.
        load_tile(1000, 0);
        wait_out_valid(lat);
        in_valid = 1'b0;
        check("latency_final", lat, 3);
        drain_all(1000);
        check("tile_count_final", tile_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before 100000");
        $fatal(1, "watchdog");
    end

endmodule
